// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store sequencing controller for the LA32R core.
//
// Takes one decoded 2R12I memory op at a time, forms the effective address
// (rj + sext(si12)), checks alignment, runs a single-outstanding valid/ready
// transaction on the data-memory port and reports either write-back data or
// an exception through a one-cycle completion pulse.
//
// Op codes (2R12I field): LD.B=0, LD.H=1, LD.W=2, ST.B=4, ST.H=5, ST.W=6,
// LD.BU=8, LD.HU=9, PRELD=0xB; 0xF (INVALID_OP_4B) and every other code are
// rejected with exception code 3.
//
// Ports:
//   clk, rst_n               core clock, asynchronous active-low reset
//   flush                    kills the result of the op in flight
//   req_valid/req_ready      op handshake from decode/issue
//   req_op/base/imm/sdata/rd decoded op fields
//   mem_req_*                data-memory request channel (word addressed)
//   mem_resp_valid/data      load response channel
//   wb_valid/we/rd/data      completion pulse and register write-back
//   exc_valid/code/badv      exception attached to the completion pulse
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_base,
  input  logic [11:0] req_imm,
  input  logic [31:0] req_sdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_badv
);

  localparam logic [3:0] OP_LD_B  = 4'h0;
  localparam logic [3:0] OP_LD_H  = 4'h1;
  localparam logic [3:0] OP_LD_W  = 4'h2;
  localparam logic [3:0] OP_ST_B  = 4'h4;
  localparam logic [3:0] OP_ST_H  = 4'h5;
  localparam logic [3:0] OP_ST_W  = 4'h6;
  localparam logic [3:0] OP_LD_BU = 4'h8;
  localparam logic [3:0] OP_LD_HU = 4'h9;
  localparam logic [3:0] OP_PRELD = 4'hB;

  localparam logic [1:0] EXC_ALE     = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_INVALID = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_e;

  // size: 0=byte, 1=half, 2=word
  typedef struct packed {
    logic       valid;
    logic       store;
    logic       preld;
    logic [1:0] size;
    logic       sext;
  } opinfo_t;

  function automatic opinfo_t decodeOp(input logic [3:0] op);
    opinfo_t d;
    d = '0;
    d.valid = 1'b1;
    case (op)
      OP_LD_B:  begin d.size = 2'd0; d.sext = 1'b1; end
      OP_LD_H:  begin d.size = 2'd1; d.sext = 1'b1; end
      OP_LD_W:  d.size = 2'd2;
      OP_LD_BU: d.size = 2'd0;
      OP_LD_HU: d.size = 2'd1;
      OP_ST_B:  begin d.size = 2'd0; d.store = 1'b1; end
      OP_ST_H:  begin d.size = 2'd1; d.store = 1'b1; end
      OP_ST_W:  begin d.size = 2'd2; d.store = 1'b1; end
      OP_PRELD: d.preld = 1'b1;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        isStore_q, isStore_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        exc_q, exc_d;
  logic [1:0]  excCode_q, excCode_d;
  logic [31:0] excBadv_q, excBadv_d;
  logic        wbWe_q, wbWe_d;
  logic [31:0] wbData_q, wbData_d;

  opinfo_t     reqInfo;
  logic [31:0] eaNext;
  logic        reqMisaligned;
  logic        accept;
  logic [7:0]  respByte;
  logic [15:0] respHalf;
  logic [31:0] loadData;

  assign reqInfo       = decodeOp(req_op);
  assign eaNext        = req_base + {{20{req_imm[11]}}, req_imm};
  assign reqMisaligned = ((reqInfo.size == 2'd1) && eaNext[0]) ||
                         ((reqInfo.size == 2'd2) && (eaNext[1:0] != 2'b00));
  assign req_ready     = (state_q == IDLE) && !flush;
  assign accept        = req_valid && req_ready;

  // Lane selection uses the latched address; halves are already known aligned.
  assign respByte = mem_resp_data[{ea_q[1:0], 3'b000} +: 8];
  assign respHalf = mem_resp_data[{ea_q[1], 4'b0000} +: 16];

  always_comb begin
    loadData = mem_resp_data;
    case (size_q)
      2'd0:    loadData = {{24{sext_q & respByte[7]}}, respByte};
      2'd1:    loadData = {{16{sext_q & respHalf[15]}}, respHalf};
      default: loadData = mem_resp_data;
    endcase
  end

  // Request channel is driven straight from latched op state so it is stable
  // for the whole ISSUE phase; valid comes from state alone so an async reset
  // drops it immediately.
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_we    = isStore_q;
  assign mem_req_addr  = {ea_q[31:2], 2'b00};

  always_comb begin
    mem_req_wstrb = 4'b0000;
    mem_req_wdata = sdata_q;
    if (isStore_q) begin
      case (size_q)
        2'd0: begin
          mem_req_wstrb = 4'b0001 << ea_q[1:0];
          mem_req_wdata = {4{sdata_q[7:0]}};
        end
        2'd1: begin
          mem_req_wstrb = 4'b0011 << ea_q[1:0];
          mem_req_wdata = {2{sdata_q[15:0]}};
        end
        default: mem_req_wstrb = 4'b1111;
      endcase
    end
  end

  // A flush seen in the DONE cycle itself suppresses the pulse as well.
  assign wb_valid  = (state_q == DONE) && !kill_q && !flush;
  assign wb_we     = wb_valid && wbWe_q;
  assign exc_valid = wb_valid && exc_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wbData_q;
  assign exc_code  = excCode_q;
  assign exc_badv  = excBadv_q;

  always_comb begin
    state_d   = state_q;
    ea_d      = ea_q;
    sdata_d   = sdata_q;
    rd_d      = rd_q;
    isStore_d = isStore_q;
    size_d    = size_q;
    sext_d    = sext_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    exc_d     = exc_q;
    excCode_d = excCode_q;
    excBadv_d = excBadv_q;
    wbWe_d    = wbWe_q;
    wbData_d  = wbData_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          ea_d      = eaNext;
          sdata_d   = req_sdata;
          rd_d      = req_rd;
          isStore_d = reqInfo.store;
          size_d    = reqInfo.size;
          sext_d    = reqInfo.sext;
          cnt_d     = 8'd0;
          exc_d     = 1'b0;
          excCode_d = 2'd0;
          excBadv_d = 32'd0;
          wbWe_d    = 1'b0;
          if (!reqInfo.valid) begin
            state_d   = DONE;
            exc_d     = 1'b1;
            excCode_d = EXC_INVALID;
            excBadv_d = eaNext;
          end else if (reqMisaligned) begin
            state_d   = DONE;
            exc_d     = 1'b1;
            excCode_d = EXC_ALE;
            excBadv_d = eaNext;
          end else if (reqInfo.preld) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush) kill_d = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = 8'd0;
          state_d = isStore_q ? DONE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (flush) kill_d = 1'b1;
        if (mem_resp_valid) begin
          wbData_d = loadData;
          wbWe_d   = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          exc_d     = 1'b1;
          excCode_d = EXC_TIMEOUT;
          excBadv_d = ea_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ea_q      <= 32'd0;
      sdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      isStore_q <= 1'b0;
      size_q    <= 2'd0;
      sext_q    <= 1'b0;
      cnt_q     <= 8'd0;
      kill_q    <= 1'b0;
      exc_q     <= 1'b0;
      excCode_q <= 2'd0;
      excBadv_q <= 32'd0;
      wbWe_q    <= 1'b0;
      wbData_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      sdata_q   <= sdata_d;
      rd_q      <= rd_d;
      isStore_q <= isStore_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      exc_q     <= exc_d;
      excCode_q <= excCode_d;
      excBadv_q <= excBadv_d;
      wbWe_q    <= wbWe_d;
      wbData_q  <= wbData_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
//
// The bench plays the data memory (programmable ready/response delays),
// offers ops, and compares every completion and bus request against a
// reference model that computes results from the ISA rules with plain
// arithmetic.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] LD_B    = 4'h0;
  localparam logic [3:0] LD_H    = 4'h1;
  localparam logic [3:0] LD_W    = 4'h2;
  localparam logic [3:0] ST_B    = 4'h4;
  localparam logic [3:0] ST_H    = 4'h5;
  localparam logic [3:0] ST_W    = 4'h6;
  localparam logic [3:0] LD_BU   = 4'h8;
  localparam logic [3:0] LD_HU   = 4'h9;
  localparam logic [3:0] PRELD   = 4'hB;
  localparam logic [3:0] INVALID = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_base;
  logic [11:0] req_imm;
  logic [31:0] req_sdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_badv;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_base       (req_base),
    .req_imm        (req_imm),
    .req_sdata      (req_sdata),
    .req_rd         (req_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_valid       (wb_valid),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_badv       (exc_badv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bus;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          wbWe;
    logic [31:0] wbData;
    bit          exc;
    logic [1:0]  code;
    logic [31:0] badv;
    int          doneK;
  } exp_t;

  // Reference behaviour: doneK is the cycle after acceptance in which the
  // completion pulse is due, given the memory's ready/response delays.
  function automatic exp_t modelOp(input logic [3:0] op, input logic [31:0] base,
                                   input logic [11:0] imm, input logic [31:0] sdata,
                                   input logic [31:0] resp, input int rdy, input int rsp);
    exp_t e;
    int size, immVal, shift;
    bit isLoad, isStore, sgn, isPreld, known;
    logic [31:0] ea, v, mask;
    e = '{default: 0};
    size = 1; isLoad = 0; isStore = 0; sgn = 0; isPreld = 0; known = 1;
    case (op)
      LD_B:    begin isLoad = 1; size = 1; sgn = 1; end
      LD_H:    begin isLoad = 1; size = 2; sgn = 1; end
      LD_W:    begin isLoad = 1; size = 4; end
      LD_BU:   begin isLoad = 1; size = 1; end
      LD_HU:   begin isLoad = 1; size = 2; end
      ST_B:    begin isStore = 1; size = 1; end
      ST_H:    begin isStore = 1; size = 2; end
      ST_W:    begin isStore = 1; size = 4; end
      PRELD:   isPreld = 1;
      default: known = 0;
    endcase
    immVal = (int'(imm) >= 2048) ? int'(imm) - 4096 : int'(imm);
    ea = base + 32'(immVal);
    shift = int'(ea % 32'd4);
    if (!known) begin
      e.exc = 1; e.code = 2'd3; e.badv = ea; e.doneK = 1;
    end else if (isPreld) begin
      e.doneK = 1;
    end else if ((ea % 32'(size)) != 0) begin
      e.exc = 1; e.code = 2'd1; e.badv = ea; e.doneK = 1;
    end else begin
      e.bus  = 1;
      e.we   = isStore;
      e.addr = ea - 32'(shift);
      if (isStore) begin
        e.strb = 4'(((1 << size) - 1) << shift);
        if (size == 1)      e.wdata = 32'(sdata[7:0]) * 32'h0101_0101;
        else if (size == 2) e.wdata = 32'(sdata[15:0]) * 32'h0001_0001;
        else                e.wdata = sdata;
        e.doneK = rdy + 2;
      end else if (rsp < 0) begin
        e.exc = 1; e.code = 2'd2; e.badv = ea; e.doneK = rdy + 2 + TO;
      end else begin
        v = resp >> (8 * shift);
        if (size < 4) begin
          mask = (32'd1 << (8 * size)) - 32'd1;
          v = v & mask;
          if (sgn && v[8*size-1]) v = v | ~mask;
        end
        e.wbWe = 1; e.wbData = v; e.doneK = rdy + rsp + 3;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Offers one op, acts as the memory for it, and checks the outcome.
  // rsp < 0 means the memory never answers; flushAt (>=1) pulses flush in
  // that cycle after acceptance.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] base,
                               input logic [11:0] imm, input logic [31:0] sdata,
                               input logic [4:0] rd, input int rdy, input int rsp,
                               input int flushAt, input logic [31:0] resp);
    exp_t e;
    int issueSeen, pulses, doneK, idleK, hsK;
    bit stableOk, killed;
    logic [31:0] bAddr, bWdata, oData, oBadv;
    logic [3:0]  bStrb;
    logic [1:0]  oCode;
    logic [4:0]  oRd;
    logic        bWe, oWe, oExc;
    e = modelOp(op, base, imm, sdata, resp, rdy, rsp);
    if (flushAt > e.doneK) flushAt = -1;
    killed = (flushAt >= 1);
    issueSeen = 0; pulses = 0; doneK = -1; idleK = -1; hsK = -1; stableOk = 1;
    bAddr = 'x; bWdata = 'x; bStrb = 'x; bWe = 1'bx;
    oData = 'x; oBadv = 'x; oCode = 'x; oRd = 'x; oWe = 1'bx; oExc = 1'bx;

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_base = base; req_imm = imm;
    req_sdata = sdata; req_rd = rd;
    #1;
    checkOutput({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_base = $urandom;
    req_imm = 12'($urandom); req_sdata = $urandom; req_rd = 5'($urandom);

    for (int k = 1; k <= 80 && idleK < 0; k++) begin
      @(negedge clk);
      flush = (k == flushAt);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data = $urandom;
      if (mem_req_valid) begin
        if (issueSeen == 0) begin
          bAddr = mem_req_addr; bWe = mem_req_we; bStrb = mem_req_wstrb; bWdata = mem_req_wdata;
        end else if (mem_req_addr !== bAddr || mem_req_we !== bWe ||
                     mem_req_wstrb !== bStrb || mem_req_wdata !== bWdata) begin
          stableOk = 0;
        end
        issueSeen++;
        if (issueSeen > rdy) begin
          mem_req_ready = 1'b1;
          hsK = k;
        end
      end
      if (hsK > 0 && hsK < k && rsp >= 0 && k == hsK + 1 + rsp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = resp;
      end
      #1;
      if (wb_valid) begin
        pulses++; doneK = k; oWe = wb_we; oRd = wb_rd; oData = wb_data;
        oExc = exc_valid; oCode = exc_code; oBadv = exc_badv;
      end
      if (req_ready) idleK = k;
    end
    flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

    checkOutput({tag, "/idle_cycle"}, 32'(idleK), 32'(e.doneK + 1));
    checkOutput({tag, "/wb_pulses"}, 32'(pulses), killed ? 32'd0 : 32'd1);
    checkOutput({tag, "/issue_cycles"}, 32'(issueSeen), e.bus ? 32'(rdy + 1) : 32'd0);
    if (!killed) begin
      checkOutput({tag, "/done_cycle"}, 32'(doneK), 32'(e.doneK));
      checkOutput({tag, "/wb_we"}, 32'(oWe), 32'(e.wbWe));
      checkOutput({tag, "/exc_valid"}, 32'(oExc), 32'(e.exc));
      if (e.wbWe) begin
        checkOutput({tag, "/wb_rd"}, 32'(oRd), 32'(rd));
        checkOutput({tag, "/wb_data"}, oData, e.wbData);
      end
      if (e.exc) begin
        checkOutput({tag, "/exc_code"}, 32'(oCode), 32'(e.code));
        checkOutput({tag, "/exc_badv"}, oBadv, e.badv);
      end
    end
    if (e.bus) begin
      checkOutput({tag, "/mem_addr"}, bAddr, e.addr);
      checkOutput({tag, "/mem_we"}, 32'(bWe), 32'(e.we));
      checkOutput({tag, "/mem_wstrb"}, 32'(bStrb), e.we ? 32'(e.strb) : 32'd0);
      if (e.we) checkOutput({tag, "/mem_wdata"}, bWdata, e.wdata);
      checkOutput({tag, "/mem_stable"}, 32'(stableOk), 32'd1);
    end
  endtask

  initial begin
    int rdy, rsp, flushAt;
    logic [31:0] base;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_base = '0;
    req_imm = '0; req_sdata = '0; req_rd = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset/req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset/mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset/wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset/wb_we", 32'(wb_we), 32'd0);
    checkOutput("reset/exc_valid", 32'(exc_valid), 32'd0);
    checkOutput("reset/wb_data", wb_data, 32'd0);
    checkOutput("reset/exc_badv", exc_badv, 32'd0);
    checkOutput("reset/exc_code", 32'(exc_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("ldb_neg", LD_B, 32'h0000_1000, 12'hFFF, 32'h0, 5'd7, 0, 0, -1, 32'h80FF_7F00);
    applyStimulus("sth_stall", ST_H, 32'h0000_2000, 12'h002, 32'h1234_ABCD, 5'd3, 3, 0, -1, 32'h0);
    applyStimulus("ldw_ale", LD_W, 32'h0000_3000, 12'h001, 32'h0, 5'd9, 0, 0, -1, 32'h0);
    applyStimulus("ldhu_timeout", LD_HU, 32'h0000_4000, 12'h002, 32'h0, 5'd4, 0, -1, -1, 32'h0);

    // A response turning up while idle must be ignored.
    repeat (3) begin
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data = $urandom;
      #1;
      checkOutput("late_resp/wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("late_resp/req_ready", 32'(req_ready), 32'd1);
    end
    mem_resp_valid = 1'b0;

    applyStimulus("ldw_flush_wait", LD_W, 32'h0000_5000, 12'h004, 32'h0, 5'd5, 0, 1, 2, 32'hDEAD_BEEF);
    applyStimulus("preld", PRELD, 32'h0000_6001, 12'h003, 32'h0, 5'd6, 0, 0, -1, 32'h0);
    applyStimulus("invalid", INVALID, 32'h0000_6100, 12'h010, 32'h0, 5'd6, 0, 0, -1, 32'h0);
    applyStimulus("preld_flush_done", PRELD, 32'h0000_6200, 12'h000, 32'h0, 5'd1, 0, 0, 1, 32'h0);
    applyStimulus("stb_lane2", ST_B, 32'h0000_7000, 12'h002, 32'h0000_00A5, 5'd2, 1, 0, -1, 32'h0);
    applyStimulus("ldh_lane2", LD_H, 32'h0000_7000, 12'h802, 32'h0, 5'd31, 2, 3, -1, 32'h8001_0203);

    // Flush while idle blocks acceptance of the offered op.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = ST_W; req_base = 32'h0000_6000; req_imm = 12'h0;
    #1;
    checkOutput("idle_flush/req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idle_flush/mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("idle_flush/req_ready_after", 32'(req_ready), 32'd1);

    // Reset in the middle of ISSUE drops the request without a clock edge.
    @(negedge clk);
    req_valid = 1'b1; req_op = LD_W; req_base = 32'h0000_8000; req_imm = 12'h0; mem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_mid/issue_valid", 32'(mem_req_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid/mem_req_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_mid/req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_mid/no_issue", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_mid/wb_valid", 32'(wb_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      base = $urandom;
      if ($urandom_range(0, 1) == 0) base[1:0] = 2'b00;
      rdy = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rsp = -1;
      else rsp = int'($urandom_range(0, TO - 1));
      if ($urandom_range(0, 5) == 0) flushAt = int'($urandom_range(1, 6));
      else flushAt = -1;
      applyStimulus($sformatf("rand%0d", i), 4'($urandom), base, 12'($urandom), $urandom,
                    5'($urandom), rdy, rsp, flushAt, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
